cache_data_assoc: RTL and testbench

N-way set-associative data array for the L1 cache, generalising the single-way block/word store. Reads all ways of the addressed set combinationally for hit selection and takes CPU byte-enable writes. Adds a line-refill engine that fills one whole line from memory in critical-word-first, wrap-around order over a valid/ready handshake. Sits between the cache controller (tag compare, way select) and the memory/bus refill path.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_way_ram.sv | 70 +++++++
 rtl/cache_data_assoc.sv | 156 +++++++++++++++
 tb/tb_cache_data_assoc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative L1 data array.
//   refill_state_t : refill engine states (IDLE, FILL, DONE)
//   CACHE_*_BIT    : default geometry of the array
//   WAYS, SETS, WRD_NUM, BE_W : counts derived from the default geometry
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } refill_state_t;

   localparam int unsigned CACHE_WAY_BIT    = 1;
   localparam int unsigned CACHE_BLKIDX_BIT = 4;
   localparam int unsigned CACHE_WRDIDX_BIT = 4;
   localparam int unsigned CACHE_DATA_W     = 32;

   localparam int unsigned WAYS    = 1 << CACHE_WAY_BIT;
   localparam int unsigned SETS    = 1 << CACHE_BLKIDX_BIT;
   localparam int unsigned WRD_NUM = 1 << CACHE_WRDIDX_BIT;
   localparam int unsigned BE_W    = CACHE_DATA_W / 8;

endpackage

// File: rtl/cache_way_ram.sv
// One way of the data array: SETS x WRD_NUM words of DATA_W bits.
// Ports:
//   clk, rst                      : clock, synchronous active-high clear
//   rd_blkidx, rd_wrdidx, rd_data : combinational read at the cpu index
//   cpu_wen/blkidx/wrdidx/wdata   : byte-enable write (cpu_wen == 0 -> no write)
//   fill_wen/blkidx/wrdidx/wdata  : full-word write from the refill engine
// The fill port exists so that a cpu write to another set of this way can
// land in the same cycle as a refill beat; the top never aims both ports
// at the same set.
module cache_way_ram
   import cache_pkg::*;
#(
   parameter int unsigned BLKIDX_BIT = CACHE_BLKIDX_BIT,
   parameter int unsigned WRDIDX_BIT = CACHE_WRDIDX_BIT,
   parameter int unsigned DATA_W     = CACHE_DATA_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BLKIDX_BIT-1:0]   rd_blkidx,
   input  logic [WRDIDX_BIT-1:0]   rd_wrdidx,
   output logic [DATA_W-1:0]       rd_data,
   input  logic [DATA_W/8-1:0]     cpu_wen,
   input  logic [BLKIDX_BIT-1:0]   cpu_blkidx,
   input  logic [WRDIDX_BIT-1:0]   cpu_wrdidx,
   input  logic [DATA_W-1:0]       cpu_wdata,
   input  logic                    fill_wen,
   input  logic [BLKIDX_BIT-1:0]   fill_blkidx,
   input  logic [WRDIDX_BIT-1:0]   fill_wrdidx,
   input  logic [DATA_W-1:0]       fill_wdata
);

   localparam int unsigned ADDR_W = BLKIDX_BIT + WRDIDX_BIT;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned NBE    = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] cpu_addr;
   logic [ADDR_W-1:0] fill_addr;
   logic [DATA_W-1:0] cpu_merged;

   assign cpu_addr  = {cpu_blkidx, cpu_wrdidx};
   assign fill_addr = {fill_blkidx, fill_wrdidx};
   assign rd_data   = mem[{rd_blkidx, rd_wrdidx}];

   // Byte merge of the cpu write against the current word.
   always_comb begin
      cpu_merged = mem[cpu_addr];
      for (int unsigned b = 0; b < NBE; b++) begin
         if (cpu_wen[b]) begin
            cpu_merged[b*8 +: 8] = cpu_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (cpu_wen != '0) begin
            mem[cpu_addr] <= cpu_merged;
         end
         if (fill_wen) begin
            mem[fill_addr] <= fill_wdata;
         end
      end
   end

endmodule

// File: rtl/cache_data_assoc.sv
// N-way set-associative L1 data array with a critical-word-first refill engine.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears the array)
//   cpu_way/blkidx/wrdidx, cpu_wdata, cpu_wen : cpu index and byte-enable write
//   cpu_rdata         : word of way cpu_way at the cpu index (combinational)
//   cpu_rdata_all     : same word from every way, way w at [w*DATA_W +: DATA_W]
//   cpu_stall         : cpu write collides with the line being filled; dropped
//   refill_start/way/blkidx/crit : line fill request (way, set, first word)
//   refill_valid/data, refill_ready : beat handshake
//   refill_busy       : engine not idle
//   refill_wmask      : words of the current line written so far
//   refill_done       : one-cycle completion pulse
module cache_data_assoc
   import cache_pkg::*;
#(
   parameter int unsigned WAY_BIT    = CACHE_WAY_BIT,
   parameter int unsigned BLKIDX_BIT = CACHE_BLKIDX_BIT,
   parameter int unsigned WRDIDX_BIT = CACHE_WRDIDX_BIT,
   parameter int unsigned DATA_W     = CACHE_DATA_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WAY_BIT-1:0]             cpu_way,
   input  logic [BLKIDX_BIT-1:0]          cpu_blkidx,
   input  logic [WRDIDX_BIT-1:0]          cpu_wrdidx,
   input  logic [DATA_W-1:0]              cpu_wdata,
   input  logic [DATA_W/8-1:0]            cpu_wen,
   output logic [DATA_W-1:0]              cpu_rdata,
   output logic [(1<<WAY_BIT)*DATA_W-1:0] cpu_rdata_all,
   output logic                           cpu_stall,
   input  logic                           refill_start,
   input  logic [WAY_BIT-1:0]             refill_way,
   input  logic [BLKIDX_BIT-1:0]          refill_blkidx,
   input  logic [WRDIDX_BIT-1:0]          refill_crit,
   input  logic                           refill_valid,
   input  logic [DATA_W-1:0]              refill_data,
   output logic                           refill_ready,
   output logic                           refill_busy,
   output logic [(1<<WRDIDX_BIT)-1:0]     refill_wmask,
   output logic                           refill_done
);

   localparam int unsigned NWAYS = 1 << WAY_BIT;
   localparam int unsigned NWRD  = 1 << WRDIDX_BIT;
   localparam int unsigned NBE   = DATA_W / 8;

   refill_state_t state;
   refill_state_t state_next;

   logic [WAY_BIT-1:0]    lat_way;
   logic [BLKIDX_BIT-1:0] lat_blk;
   logic [WRDIDX_BIT-1:0] lat_crit;
   logic [WRDIDX_BIT:0]   cnt;
   logic [NWRD-1:0]       wmask;

   logic                  beat;
   logic                  last_beat;
   logic                  cpu_write;
   logic [WRDIDX_BIT-1:0] fill_wrdidx;
   logic [DATA_W-1:0]     way_rdata [NWAYS];

   // Beat target wraps around the line: carry out of the add is dropped.
   assign fill_wrdidx = lat_crit + cnt[WRDIDX_BIT-1:0];
   assign beat        = (state == FILL) && refill_valid;
   assign last_beat   = beat && (cnt == (WRDIDX_BIT+1)'(NWRD - 1));

   assign cpu_stall   = (state == FILL) && (cpu_wen != '0) &&
                        (cpu_way == lat_way) && (cpu_blkidx == lat_blk);
   assign cpu_write   = (cpu_wen != '0) && !cpu_stall;

   assign refill_busy  = (state != IDLE);
   assign refill_wmask = wmask;

   always_comb begin
      state_next   = state;
      refill_ready = 1'b0;
      refill_done  = 1'b0;
      case (state)
         IDLE: begin
            if (refill_start) begin
               state_next = FILL;
            end
         end
         FILL: begin
            refill_ready = 1'b1;
            if (last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            refill_done = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lat_way  <= '0;
         lat_blk  <= '0;
         lat_crit <= '0;
         cnt      <= '0;
         wmask    <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && refill_start) begin
            lat_way  <= refill_way;
            lat_blk  <= refill_blkidx;
            lat_crit <= refill_crit;
            cnt      <= '0;
            wmask    <= '0;
         end
         if (beat) begin
            cnt                <= cnt + 1'b1;
            wmask[fill_wrdidx] <= 1'b1;
         end
      end
   end

   for (genvar w = 0; w < NWAYS; w++) begin : g_way
      logic [NBE-1:0] way_cpu_wen;
      logic           way_fill_wen;

      assign way_cpu_wen  = (cpu_write && cpu_way == WAY_BIT'(w)) ? cpu_wen : '0;
      assign way_fill_wen = beat && (lat_way == WAY_BIT'(w));

      cache_way_ram #(
         .BLKIDX_BIT (BLKIDX_BIT),
         .WRDIDX_BIT (WRDIDX_BIT),
         .DATA_W     (DATA_W)
      ) u_ram (
         .clk         (clk),
         .rst         (rst),
         .rd_blkidx   (cpu_blkidx),
         .rd_wrdidx   (cpu_wrdidx),
         .rd_data     (way_rdata[w]),
         .cpu_wen     (way_cpu_wen),
         .cpu_blkidx  (cpu_blkidx),
         .cpu_wrdidx  (cpu_wrdidx),
         .cpu_wdata   (cpu_wdata),
         .fill_wen    (way_fill_wen),
         .fill_blkidx (lat_blk),
         .fill_wrdidx (fill_wrdidx),
         .fill_wdata  (refill_data)
      );

      assign cpu_rdata_all[w*DATA_W +: DATA_W] = way_rdata[w];
   end

   assign cpu_rdata = way_rdata[cpu_way];

endmodule

// File: tb/tb_cache_data_assoc.sv
// Directed bench for cache_data_assoc with default geometry
// (2 ways, 16 sets, 16 words/line, 32-bit words).
module tb_cache_data_assoc;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:0]  cpu_way;
   logic [3:0]  cpu_blkidx;
   logic [3:0]  cpu_wrdidx;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_rdata;
   logic [63:0] cpu_rdata_all;
   logic        cpu_stall;
   logic        refill_start;
   logic [0:0]  refill_way;
   logic [3:0]  refill_blkidx;
   logic [3:0]  refill_crit;
   logic        refill_valid;
   logic [31:0] refill_data;
   logic        refill_ready;
   logic        refill_busy;
   logic [15:0] refill_wmask;
   logic        refill_done;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   cache_data_assoc #(
      .WAY_BIT    (1),
      .BLKIDX_BIT (4),
      .WRDIDX_BIT (4),
      .DATA_W     (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_way       (cpu_way),
      .cpu_blkidx    (cpu_blkidx),
      .cpu_wrdidx    (cpu_wrdidx),
      .cpu_wdata     (cpu_wdata),
      .cpu_wen       (cpu_wen),
      .cpu_rdata     (cpu_rdata),
      .cpu_rdata_all (cpu_rdata_all),
      .cpu_stall     (cpu_stall),
      .refill_start  (refill_start),
      .refill_way    (refill_way),
      .refill_blkidx (refill_blkidx),
      .refill_crit   (refill_crit),
      .refill_valid  (refill_valid),
      .refill_data   (refill_data),
      .refill_ready  (refill_ready),
      .refill_busy   (refill_busy),
      .refill_wmask  (refill_wmask),
      .refill_done   (refill_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, outputs are checked after that.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input int way, input int blk, input int wrd,
                           input logic [31:0] exp, input string tag);
      logic [31:0] b;
      logic [31:0] w;
      b = blk;
      w = wrd;
      cpu_blkidx = b[3:0];
      cpu_wrdidx = w[3:0];
      #1;
      chk(tag, cpu_rdata_all[way*32 +: 32], exp);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      int k;
      logic [15:0] exp_mask;
      logic [31:0] tmp;

      rst = 1'b1;
      cpu_way = '0; cpu_blkidx = '0; cpu_wrdidx = '0; cpu_wdata = '0; cpu_wen = '0;
      refill_start = 1'b0; refill_way = '0; refill_blkidx = '0; refill_crit = '0;
      refill_valid = 1'b0; refill_data = '0;
      tick();
      tick();
      chk("rst_stall", cpu_stall, 0);
      chk("rst_busy", refill_busy, 0);
      chk("rst_done", refill_done, 0);
      chk("rst_ready", refill_ready, 0);
      chk("rst_wmask", refill_wmask, 0);
      rst = 1'b0;
      tick();
      for (int s = 0; s < 16; s++) begin
         for (int w = 0; w < 16; w++) begin
            rd_check(0, s, w, 32'h0, "rst_w0");
            rd_check(1, s, w, 32'h0, "rst_w1");
         end
      end

      // Byte-enable write
      cpu_way = 1'b1; cpu_blkidx = 4'd3; cpu_wrdidx = 4'd5;
      cpu_wdata = 32'hAABBCCDD; cpu_wen = 4'b0101;
      tick();
      cpu_wen = '0;
      #1;
      chk("be_rdata", cpu_rdata, 32'h00BB00DD);
      chk("be_way0", cpu_rdata_all[31:0], 32'h0);

      // Back-to-back refill way0 set2 crit 14
      refill_start = 1'b1; refill_way = 1'b0; refill_blkidx = 4'd2; refill_crit = 4'd14;
      #1;
      chk("r1_idle_busy", refill_busy, 0);
      tick();
      refill_start = 1'b0;
      busy_cnt = 0;
      for (int b = 0; b < 16; b++) begin
         refill_valid = 1'b1;
         refill_data = 32'h1000 + b;
         #1;
         chk("r1_ready", refill_ready, 1);
         chk("r1_nodone", refill_done, 0);
         if (refill_busy) busy_cnt++;
         tick();
      end
      refill_valid = 1'b0;
      chk("r1_done", refill_done, 1);
      chk("r1_done_ready", refill_ready, 0);
      chk("r1_wmask", refill_wmask, 16'hFFFF);
      if (refill_busy) busy_cnt++;
      tick();
      chk("r1_done_clr", refill_done, 0);
      chk("r1_idle", refill_busy, 0);
      chk("r1_busy_cycles", busy_cnt, 17);
      for (int b = 0; b < 16; b++) begin
         rd_check(0, 2, (14 + b) % 16, 32'h1000 + b, "r1_data");
      end
      rd_check(1, 3, 5, 32'h00BB00DD, "r1_keep_be");

      // Refill way1 set4 crit 3, valid every other cycle
      refill_start = 1'b1; refill_way = 1'b1; refill_blkidx = 4'd4; refill_crit = 4'd3;
      tick();
      refill_start = 1'b0;
      chk("r2_wmask0", refill_wmask, 16'h0);
      k = 0; exp_mask = '0; done_cnt = 0;
      for (int c = 0; c < 80 && done_cnt == 0; c++) begin
         refill_valid = (c % 2 == 0);
         refill_data = refill_valid ? 32'h2000 + k : 32'hBAD0BAD0;
         #1;
         chk("r2_wmask", refill_wmask, exp_mask);
         tick();
         if (refill_valid) begin
            exp_mask[(3 + k) % 16] = 1'b1;
            k++;
         end
         if (refill_done) done_cnt++;
      end
      refill_valid = 1'b0;
      chk("r2_done_seen", done_cnt, 1);
      chk("r2_wmask_full", refill_wmask, 16'hFFFF);
      tick();
      if (refill_done) done_cnt++;
      chk("r2_done_once", done_cnt, 1);
      for (int b = 0; b < 16; b++) begin
         rd_check(1, 4, (3 + b) % 16, 32'h2000 + b, "r2_data");
      end

      // Collision: fill way1 set2 crit 0
      refill_start = 1'b1; refill_way = 1'b1; refill_blkidx = 4'd2; refill_crit = 4'd0;
      tick();
      refill_start = 1'b0;
      refill_valid = 1'b1; refill_data = 32'h3000;
      cpu_way = 1'b1; cpu_blkidx = 4'd2; cpu_wrdidx = 4'd7;
      cpu_wdata = 32'hDEADBEEF; cpu_wen = 4'hF;
      #1;
      chk("col_stall", cpu_stall, 1);
      tick();
      cpu_wen = '0; refill_valid = 1'b0;
      rd_check(1, 2, 7, 32'h0, "col_blocked");
      rd_check(1, 2, 0, 32'h3000, "col_beat0");
      refill_valid = 1'b1; refill_data = 32'h3001;
      cpu_way = 1'b0; cpu_blkidx = 4'd2; cpu_wrdidx = 4'd9;
      cpu_wdata = 32'h12345678; cpu_wen = 4'hF;
      #1;
      chk("col_nostall", cpu_stall, 0);
      tick();
      cpu_wen = '0; refill_valid = 1'b0;
      rd_check(0, 2, 9, 32'h12345678, "col_cpu_other");
      rd_check(1, 2, 1, 32'h3001, "col_beat1");
      for (int b = 2; b < 16; b++) begin
         refill_valid = 1'b1;
         refill_data = 32'h3000 + b;
         tick();
      end
      refill_valid = 1'b0;
      chk("col_done", refill_done, 1);
      tick();
      rd_check(1, 2, 7, 32'h3007, "col_word7");

      // Reset in the middle of a fill
      refill_start = 1'b1; refill_way = 1'b0; refill_blkidx = 4'd5; refill_crit = 4'd0;
      tick();
      refill_start = 1'b0;
      for (int b = 0; b < 5; b++) begin
         refill_valid = 1'b1;
         refill_data = 32'h4000 + b;
         tick();
      end
      tmp = {16'h0, refill_wmask};
      chk("mr_wmask5", tmp, 32'h1F);
      refill_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("mr_busy", refill_busy, 0);
      chk("mr_done", refill_done, 0);
      chk("mr_ready", refill_ready, 0);
      chk("mr_wmask", refill_wmask, 0);
      rd_check(0, 5, 0, 32'h0, "mr_clr_fill");
      rd_check(0, 5, 4, 32'h0, "mr_clr_fill4");
      rd_check(0, 2, 14, 32'h0, "mr_clr_old");
      rd_check(1, 3, 5, 32'h0, "mr_clr_be");
      rst = 1'b0;
      refill_start = 1'b1; refill_way = 1'b1; refill_blkidx = 4'd6; refill_crit = 4'd2;
      tick();
      refill_start = 1'b0;
      chk("mr_restart_busy", refill_busy, 1);
      chk("mr_restart_ready", refill_ready, 1);
      chk("mr_restart_wmask", refill_wmask, 0);
      done_cnt = 0;
      for (int b = 0; b < 16; b++) begin
         refill_valid = 1'b1;
         refill_data = 32'h5000 + b;
         tick();
      end
      refill_valid = 1'b0;
      chk("mr_restart_done", refill_done, 1);
      tick();
      rd_check(1, 6, 2, 32'h5000, "mr_restart_crit");
      rd_check(1, 6, 1, 32'h500F, "mr_restart_last");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
